// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-ported memory between core0 and core1
// with round-robin grants, held off while the external loader owns memory.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  is_loading_memory_into_core,

    input  logic                  core0_req,
    input  logic                  core0_we,
    input  logic [ADDR_WIDTH-1:0] core0_addr,
    input  logic [DATA_WIDTH-1:0] core0_wr_data,
    output logic                  core0_ready,
    output logic [DATA_WIDTH-1:0] core0_rd_data,

    input  logic                  core1_req,
    input  logic                  core1_we,
    input  logic [ADDR_WIDTH-1:0] core1_addr,
    input  logic [DATA_WIDTH-1:0] core1_wr_data,
    output logic                  core1_ready,
    output logic [DATA_WIDTH-1:0] core1_rd_data,

    output logic                  mem_requested,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_reset_req,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_ready
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP,
        RELEASE
    } state_t;

    state_t state, state_n;

    logic last_grant, last_grant_n;
    logic gnt, gnt_n;
    logic pick;
    logic gnt_req;

    logic                  mem_requested_n;
    logic                  mem_we_n;
    logic [ADDR_WIDTH-1:0] mem_addr_n;
    logic [DATA_WIDTH-1:0] mem_wr_data_n;
    logic                  mem_reset_req_n;
    logic                  core0_ready_n;
    logic                  core1_ready_n;
    logic [DATA_WIDTH-1:0] core0_rd_data_n;
    logic [DATA_WIDTH-1:0] core1_rd_data_n;

    // On a tie the core that did not win last time goes next
    always_comb begin
        pick = core1_req;
        if (core0_req && core1_req) begin
            pick = ~last_grant;
        end
    end

    assign gnt_req = gnt ? core1_req : core0_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n         = state;
        last_grant_n    = last_grant;
        gnt_n           = gnt;
        mem_requested_n = mem_requested;
        mem_we_n        = mem_we;
        mem_addr_n      = mem_addr;
        mem_wr_data_n   = mem_wr_data;
        mem_reset_req_n = 1'b0;
        core0_ready_n   = 1'b0;
        core1_ready_n   = 1'b0;
        core0_rd_data_n = core0_rd_data;
        core1_rd_data_n = core1_rd_data;

        unique case (state)
            IDLE: begin
                if (!is_loading_memory_into_core &&
                    (core0_req || core1_req)) begin
                    gnt_n           = pick;
                    last_grant_n    = pick;
                    mem_requested_n = 1'b1;
                    mem_we_n        = pick ? core1_we : core0_we;
                    mem_addr_n      = pick ? core1_addr : core0_addr;
                    mem_wr_data_n   = pick ? core1_wr_data
                                           : core0_wr_data;
                    state_n         = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    mem_requested_n = 1'b0;
                    mem_reset_req_n = 1'b1;
                    if (gnt) begin
                        core1_rd_data_n = mem_rd_data;
                        core1_ready_n   = 1'b1;
                    end else begin
                        core0_rd_data_n = mem_rd_data;
                        core0_ready_n   = 1'b1;
                    end
                    state_n = RESP;
                end
            end
            RESP: begin
                state_n = RELEASE;
            end
            RELEASE: begin
                // A request still held after completion must not reissue
                if (!gnt_req) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant    <= 1'b1;
            gnt           <= 1'b0;
            mem_requested <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wr_data   <= '0;
            mem_reset_req <= 1'b0;
            core0_ready   <= 1'b0;
            core1_ready   <= 1'b0;
            core0_rd_data <= '0;
            core1_rd_data <= '0;
        end else begin
            last_grant    <= last_grant_n;
            gnt           <= gnt_n;
            mem_requested <= mem_requested_n;
            mem_we        <= mem_we_n;
            mem_addr      <= mem_addr_n;
            mem_wr_data   <= mem_wr_data_n;
            mem_reset_req <= mem_reset_req_n;
            core0_ready   <= core0_ready_n;
            core1_ready   <= core1_ready_n;
            core0_rd_data <= core0_rd_data_n;
            core1_rd_data <= core1_rd_data_n;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level round-robin model of the arbiter.
module tb_mem_arbiter;

    localparam int AW = 20;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          is_loading_memory_into_core;
    logic          core0_req, core0_we;
    logic [AW-1:0] core0_addr;
    logic [DW-1:0] core0_wr_data;
    logic          core0_ready;
    logic [DW-1:0] core0_rd_data;
    logic          core1_req, core1_we;
    logic [AW-1:0] core1_addr;
    logic [DW-1:0] core1_wr_data;
    logic          core1_ready;
    logic [DW-1:0] core1_rd_data;
    logic          mem_requested, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic          mem_reset_req;
    logic [DW-1:0] mem_rd_data;
    logic          mem_ready;

    int n_vec = 0;
    int n_bad = 0;

    // memory responder state
    int            mem_lat = 1;
    int            mem_cnt = 0;
    bit            fix_en = 1'b0;
    bit            rand_lat = 1'b0;
    logic [DW-1:0] fix_data = '0;
    logic [DW-1:0] mem_sent = '0;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk                         (clk),
        .reset                       (reset),
        .is_loading_memory_into_core (is_loading_memory_into_core),
        .core0_req                   (core0_req),
        .core0_we                    (core0_we),
        .core0_addr                  (core0_addr),
        .core0_wr_data               (core0_wr_data),
        .core0_ready                 (core0_ready),
        .core0_rd_data               (core0_rd_data),
        .core1_req                   (core1_req),
        .core1_we                    (core1_we),
        .core1_addr                  (core1_addr),
        .core1_wr_data               (core1_wr_data),
        .core1_ready                 (core1_ready),
        .core1_rd_data               (core1_rd_data),
        .mem_requested               (mem_requested),
        .mem_we                      (mem_we),
        .mem_addr                    (mem_addr),
        .mem_wr_data                 (mem_wr_data),
        .mem_reset_req               (mem_reset_req),
        .mem_rd_data                 (mem_rd_data),
        .mem_ready                   (mem_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock; outputs are read 1ns after the edge, memory answers here
    task automatic step();
        @(posedge clk);
        #1;
        if (mem_ready) begin
            mem_ready = 1'b0;
            mem_cnt   = 0;
        end else if (mem_requested) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
                mem_sent = fix_en ? fix_data
                         : {$urandom, $urandom, $urandom, $urandom};
                mem_rd_data = mem_sent;
                mem_ready   = 1'b1;
                if (rand_lat) mem_lat = $urandom_range(1, 4);
            end
        end else begin
            mem_cnt = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        is_loading_memory_into_core = 1'b0;
        core0_req = 1'b0; core0_we = 1'b0;
        core0_addr = '0;  core0_wr_data = '0;
        core1_req = 1'b0; core1_we = 1'b0;
        core1_addr = '0;  core1_wr_data = '0;
        mem_ready = 1'b0; mem_rd_data = '0; mem_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_grant(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            if (mem_requested) ok = 1'b1;
        end
    endtask

    task automatic wait_ready(input int budget, output int who);
        who = -1;
        for (int i = 0; i < budget && who < 0; i++) begin
            step();
            if (core0_ready) who = 0;
            else if (core1_ready) who = 1;
        end
    endtask

    // drop the request long enough to be seen, then raise it again
    task automatic release_core(input int c);
        if (c == 0) core0_req = 1'b0; else core1_req = 1'b0;
        step();
        step();
        if (c == 0) core0_req = 1'b1; else core1_req = 1'b1;
    endtask

    // transaction-level model state for the random phase
    logic          drv_req[2];
    logic          drv_we[2];
    logic [AW-1:0] drv_addr[2];
    logic [DW-1:0] drv_data[2];
    int            phase[2], hold[2], gap[2];
    bit            dropped[2];
    logic [DW-1:0] m_rd[2];
    bit            pr[2];
    bit            pl, pm, m_busy;
    int            m_last, m_owner, e, stall;

    initial begin
        bit ok;
        int who;
        int nrdy, rises;
        bit stable;
        int ord[4];

        // reset values
        reset = 1'b1;
        is_loading_memory_into_core = 1'b0;
        core0_req = 1'b0; core0_we = 1'b0;
        core0_addr = '0;  core0_wr_data = '0;
        core1_req = 1'b0; core1_we = 1'b0;
        core1_addr = '0;  core1_wr_data = '0;
        mem_ready = 1'b0; mem_rd_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_requested", mem_requested, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_reset_req", mem_reset_req, 0);
        chk("rst_ready0", core0_ready, 0);
        chk("rst_ready1", core1_ready, 0);
        chk("rst_rd0", core0_rd_data, 0);
        chk("rst_rd1", core1_rd_data, 0);
        reset = 1'b0;

        // single read
        fix_en = 1'b1;
        fix_data = 128'hDEADBEEF;
        mem_lat = 1;
        core0_addr = 20'h00010;
        core0_req = 1'b1;
        step();
        chk("rd_mem_requested", mem_requested, 1);
        chk("rd_mem_addr", mem_addr, 20'h00010);
        chk("rd_mem_we", mem_we, 0);
        step();
        chk("rd_ready0", core0_ready, 1);
        chk("rd_data0", core0_rd_data[31:0], 32'hDEADBEEF);
        chk("rd_mem_reset_req", mem_reset_req, 1);
        chk("rd_ready1_quiet", core1_ready, 0);
        chk("rd_req_dropped", mem_requested, 0);
        core0_req = 1'b0;
        step();
        chk("rd_ready0_pulse", core0_ready, 0);
        chk("rd_reset_req_pulse", mem_reset_req, 0);
        step();
        fix_en = 1'b0;

        // simultaneous requests from reset, then alternating
        do_reset();
        core0_addr = 20'h00100;
        core1_addr = 20'h00200;
        core0_req = 1'b1;
        core1_req = 1'b1;
        ord = '{0, 1, 0, 1};
        for (int k = 0; k < 4; k++) begin
            wait_grant(20, ok);
            chk("tie_grant", ok, 1);
            chk("tie_addr", mem_addr,
                (ord[k] == 1) ? 20'h00200 : 20'h00100);
            wait_ready(20, who);
            chk("tie_ready_core", who, ord[k]);
            release_core(ord[k]);
        end

        // loader blocks grants
        do_reset();
        is_loading_memory_into_core = 1'b1;
        core1_addr = 20'h33333;
        core1_req = 1'b1;
        rises = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (mem_requested) rises++;
        end
        chk("load_no_request", rises, 0);
        is_loading_memory_into_core = 1'b0;
        step();
        chk("load_release_req", mem_requested, 1);
        chk("load_release_addr", mem_addr, 20'h33333);
        // loader returns mid-transaction: completes, then blocks
        is_loading_memory_into_core = 1'b1;
        wait_ready(20, who);
        chk("load_mid_complete", who, 1);
        core1_req = 1'b0;
        core0_addr = 20'h04444;
        core0_req = 1'b1;
        rises = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (mem_requested) rises++;
        end
        chk("load_hold_after", rises, 0);
        is_loading_memory_into_core = 1'b0;
        wait_grant(5, ok);
        chk("load_resume", ok, 1);
        chk("load_resume_addr", mem_addr, 20'h04444);

        // write forwarding with 5-cycle memory
        do_reset();
        mem_lat = 5;
        core1_we = 1'b1;
        core1_addr = 20'h0ABCD;
        core1_wr_data = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
        core1_req = 1'b1;
        step();
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_addr", mem_addr, 20'h0ABCD);
        chk("wr_mem_data", mem_wr_data, core1_wr_data);
        nrdy = 0;
        stable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (mem_requested && (mem_we !== 1'b1 ||
                mem_addr !== 20'h0ABCD ||
                mem_wr_data !== 128'h12345678_9ABCDEF0_0FEDCBA9_87654321))
                stable = 1'b0;
            if (core1_ready) begin
                nrdy++;
                core1_req = 1'b0;
            end
            if (core0_ready) nrdy += 100;
        end
        chk("wr_stable", stable, 1);
        chk("wr_ready_once", nrdy, 1);
        mem_lat = 1;

        // held request is not reissued
        core1_we = 1'b0;
        core0_addr = 20'h00777;
        core0_req = 1'b1;
        wait_grant(10, ok);
        chk("held_first_grant", ok, 1);
        wait_ready(10, who);
        chk("held_first_ready", who, 0);
        rises = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (mem_requested) rises++;
        end
        chk("held_no_reissue", rises, 0);
        core0_req = 1'b0;
        step();
        step();
        core0_req = 1'b1;
        wait_grant(10, ok);
        chk("held_regrant", ok, 1);
        wait_ready(10, who);
        chk("held_regrant_ready", who, 0);
        core0_req = 1'b0;
        step();
        step();

        // asynchronous reset mid-ISSUE
        mem_lat = 20;
        core1_req = 1'b1;
        core1_addr = 20'h01111;
        wait_grant(10, ok);
        chk("arst_grant", ok, 1);
        step();
        #3;
        reset = 1'b1;
        #1;
        chk("arst_mem_requested", mem_requested, 0);
        chk("arst_mem_reset_req", mem_reset_req, 0);
        chk("arst_ready0", core0_ready, 0);
        chk("arst_ready1", core1_ready, 0);
        core1_req = 1'b0;
        mem_ready = 1'b0;
        mem_cnt = 0;
        mem_lat = 1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        core0_addr = 20'h0AAAA;
        core1_addr = 20'h0BBBB;
        core0_req = 1'b1;
        core1_req = 1'b1;
        step();
        chk("arst_tie_req", mem_requested, 1);
        chk("arst_tie_core0", mem_addr, 20'h0AAAA);

        // randomized traffic against the round-robin model
        do_reset();
        rand_lat = 1'b1;
        for (int c = 0; c < 2; c++) begin
            drv_req[c] = 1'b0; drv_we[c] = 1'b0;
            drv_addr[c] = '0; drv_data[c] = '0;
            phase[c] = 0; hold[c] = 0; gap[c] = 0;
            dropped[c] = 1'b1; m_rd[c] = '0; pr[c] = 1'b0;
        end
        pl = 1'b0; pm = 1'b0; m_busy = 1'b0;
        m_last = 1; m_owner = 0; stall = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            if (mem_requested && !pm) begin
                e = (pr[0] && pr[1]) ? ((m_last == 1) ? 0 : 1)
                  : (pr[1] ? 1 : 0);
                chk("rr_req_seen", pr[0] | pr[1], 1);
                chk("rr_grant_addr", mem_addr, drv_addr[e]);
                chk("rr_grant_we", mem_we, drv_we[e]);
                chk("rr_grant_data", mem_wr_data, drv_data[e]);
                chk("rr_loader_off", pl, 0);
                chk("rr_no_overlap", m_busy, 0);
                chk("rr_fresh_req", dropped[e], 1);
                m_last = e;
                m_owner = e;
                m_busy = 1'b1;
                dropped[e] = 1'b0;
            end
            if (core0_ready || core1_ready) begin
                chk("rr_ready_excl", core0_ready & core1_ready, 0);
                chk("rr_ready_owner", core1_ready, m_owner);
                chk("rr_ready_busy", m_busy, 1);
                m_rd[m_owner] = mem_sent;
                chk("rr_rd0", core0_rd_data, m_rd[0]);
                chk("rr_rd1", core1_rd_data, m_rd[1]);
                m_busy = 1'b0;
            end
            if (!m_busy && !pl && (pr[0] || pr[1]) && !mem_requested)
                stall++;
            else
                stall = 0;
            if (stall > 16) begin
                chk("rr_stall", stall, 0);
                stall = 0;
            end
            for (int c = 0; c < 2; c++) begin
                case (phase[c])
                    0: begin
                        if (gap[c] > 0) begin
                            gap[c]--;
                        end else if ($urandom_range(0, 2) == 0) begin
                            drv_req[c]  = 1'b1;
                            drv_we[c]   = 1'($urandom_range(0, 1));
                            drv_addr[c] = AW'($urandom);
                            drv_data[c] = {$urandom, $urandom,
                                           $urandom, $urandom};
                            phase[c] = 1;
                        end
                    end
                    1: begin
                        if ((c == 0) ? core0_ready : core1_ready) begin
                            phase[c] = 2;
                            hold[c] = $urandom_range(0, 3);
                        end
                    end
                    default: begin
                        if (hold[c] == 0) begin
                            drv_req[c] = 1'b0;
                            phase[c] = 0;
                            gap[c] = 2;
                            dropped[c] = 1'b1;
                        end else begin
                            hold[c]--;
                        end
                    end
                endcase
            end
            if ($urandom_range(0, 39) == 0)
                is_loading_memory_into_core = ~is_loading_memory_into_core;
            core0_req = drv_req[0]; core0_we = drv_we[0];
            core0_addr = drv_addr[0]; core0_wr_data = drv_data[0];
            core1_req = drv_req[1]; core1_we = drv_we[1];
            core1_addr = drv_addr[1]; core1_wr_data = drv_data[1];
            pr[0] = drv_req[0];
            pr[1] = drv_req[1];
            pl = is_loading_memory_into_core;
            pm = mem_requested;
        end
        rand_lat = 1'b0;
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
